// File: rtl/result_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : result_display_scanner
// Description : Shows a 32-bit value as eight hex digits on a multiplexed,
//               active-low 7-segment display. The value is captured once per
//               frame, and the anodes are blanked at the start of each slot.
// Revision    : 1.0 - initial release
// ============================================================================
module result_display_scanner #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        freeze,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        frame_done
);

    localparam int c_PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(CLK_DIV - 1);
    localparam logic [c_PRE_W-1:0] c_BLANK_END = c_PRE_W'(BLANK_CYCLES);
    localparam logic [6:0] c_SEG_OFF = 7'h7F;
    localparam logic [7:0] c_AN_OFF  = 8'hFF;

    logic [c_PRE_W-1:0] r_prescaler;
    logic [c_PRE_W-1:0] w_prescalerNext;
    logic [2:0]         r_digitIdx;
    logic [2:0]         w_digitIdxNext;
    logic [31:0]        r_snapshot;
    logic [31:0]        w_snapshotNext;
    logic [6:0]         r_seg;
    logic [7:0]         r_an;

    logic               w_tick;
    logic               w_frameBoundary;
    logic               w_slotStart;
    logic [4:0]         w_bitBase;
    logic [3:0]         w_nibble;
    logic [31:0]        w_upperBits;
    logic               w_leadZero;
    logic [6:0]         w_hexCode;
    logic [6:0]         w_segNext;
    logic [7:0]         w_anNext;

    assign w_tick          = (r_prescaler == c_PRE_LAST);
    assign w_frameBoundary = w_tick && (r_digitIdx == 3'd7);

    always_comb begin
        w_prescalerNext = r_prescaler + c_PRE_W'(1);
        w_digitIdxNext  = r_digitIdx;
        w_snapshotNext  = r_snapshot;
        if (w_tick) begin
            w_prescalerNext = '0;
            w_digitIdxNext  = r_digitIdx + 3'd1;
        end
        if (w_frameBoundary && !freeze) begin
            w_snapshotNext = data_in;
        end
    end

    // Display outputs are derived from next-state so they change on the same
    // edge as the slot they belong to.
    assign w_slotStart = (w_prescalerNext == '0);
    assign w_bitBase   = {w_digitIdxNext, 2'b00};
    assign w_nibble    = w_snapshotNext[w_bitBase +: 4];
    assign w_upperBits = w_snapshotNext >> w_bitBase;
    assign w_leadZero  = (w_digitIdxNext != 3'd0) && (w_upperBits == 32'd0);

    always_comb begin
        w_hexCode = c_SEG_OFF;
        case (w_nibble)
            4'h0: w_hexCode = 7'h40;
            4'h1: w_hexCode = 7'h79;
            4'h2: w_hexCode = 7'h24;
            4'h3: w_hexCode = 7'h30;
            4'h4: w_hexCode = 7'h19;
            4'h5: w_hexCode = 7'h12;
            4'h6: w_hexCode = 7'h02;
            4'h7: w_hexCode = 7'h78;
            4'h8: w_hexCode = 7'h00;
            4'h9: w_hexCode = 7'h10;
            4'hA: w_hexCode = 7'h08;
            4'hB: w_hexCode = 7'h03;
            4'hC: w_hexCode = 7'h46;
            4'hD: w_hexCode = 7'h21;
            4'hE: w_hexCode = 7'h06;
            4'hF: w_hexCode = 7'h0E;
            default: w_hexCode = c_SEG_OFF;
        endcase
    end

    assign w_segNext = (blank_lz && w_leadZero) ? c_SEG_OFF : w_hexCode;
    assign w_anNext  = (w_prescalerNext < c_BLANK_END) ? c_AN_OFF
                                                       : ~(8'b1 << w_digitIdxNext);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prescaler <= '0;
            r_digitIdx  <= 3'd0;
            r_snapshot  <= 32'd0;
            r_seg       <= c_SEG_OFF;
            r_an        <= c_AN_OFF;
        end else begin
            r_prescaler <= w_prescalerNext;
            r_digitIdx  <= w_digitIdxNext;
            r_snapshot  <= w_snapshotNext;
            r_an        <= w_anNext;
            // Segments switch only while the anodes are dark.
            if (w_slotStart) begin
                r_seg <= w_segNext;
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = w_frameBoundary;

endmodule
`default_nettype wire
